button_cmd_encoder: RTL

Front-end for the four push buttons that feed the LED shift controller. It synchronizes and debounces `button0`..`button3` and turns each debounced press into a one-cycle edge pulse. It queues presses per button and presents them one at a time as a 2-bit command over a valid/ready handshake. The LED shift controller consumes that command, so it no longer samples raw button levels.

---
 rtl/button_cmd_encoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/button_cmd_encoder.sv
// Synchronizes and debounces four push buttons, turns each debounced press into a
// one-cycle pulse and queues presses as 2-bit commands on a valid/ready output.
module button_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button0,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready,
    output logic       overrun
);
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // while cmd_valid is high and cmd_ready low, cmd_code is held and cmd_valid stays up.

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_level;
    logic [3:0]    r_pulse;
    logic [3:0]    r_pend;
    logic [CW-1:0] r_cnt [4];
    logic          r_valid;
    logic [1:0]    r_code;
    logic          r_overrun;

    logic [3:0]    w_rise;
    logic [3:0]    w_sel_mask;
    logic [1:0]    w_sel_idx;
    logic          w_load;
    logic [3:0]    w_clear;

    assign w_raw = {button3, button2, button1, button0};

    always_comb begin
        w_rise     = 4'b0000;
        w_sel_mask = 4'b0000;
        w_sel_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_rise[i] = r_sync2[i] && !r_level[i] && (r_cnt[i] == CNT_MAX);
        end
        // Scan downward so the lowest set pending bit is the one that sticks.
        for (int i = 3; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel_idx  = 2'(i);
                w_sel_mask = 4'b0001 << i;
            end
        end
        w_load  = !r_valid || cmd_ready;
        w_clear = w_load ? w_sel_mask : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 4'b0000;
            r_sync2   <= 4'b0000;
            r_level   <= 4'b0000;
            r_pulse   <= 4'b0000;
            r_pend    <= 4'b0000;
            r_valid   <= 1'b0;
            r_code    <= 2'd0;
            r_overrun <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            r_pulse <= w_rise;
            // A press landing on the bit being loaded re-arms it; that is not a lost press.
            r_pend  <= (r_pend & ~w_clear) | w_rise;
            if (|(w_rise & r_pend & ~w_clear)) begin
                r_overrun <= 1'b1;
            end
            if (w_load) begin
                if (|r_pend) begin
                    r_valid <= 1'b1;
                    r_code  <= w_sel_idx;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;
    assign cmd_valid = r_valid;
    assign cmd_code  = r_code;
    assign overrun   = r_overrun;

endmodule
